wave_sequencer: RTL and testbench

- Capture-and-plot controller for the SSD1306 waveform plotter peripheral.
- Samples CH probe lines into an on-chip buffer, with an optional rising-edge trigger.
- Replays the buffer as one OLED page (track) per channel by driving the plotter's register port (address/data_write/data_in) and polling its idle status bit.
- Sits between the capture inputs and the plotter; owns the plotter's command port while busy.

---
 rtl/wave_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_wave_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_sequencer.sv
// rtl/wave_sequencer.sv - capture-and-plot controller driving the SSD1306 plotter register port
module wave_sequencer #(
    parameter int CH    = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CH-1:0] probe,
    input  logic [7:0]    div,
    input  logic          trig_en,
    input  logic [2:0]    trig_ch,
    input  logic [3:0]    presc,
    input  logic          gnd,
    input  logic          plt_idle,
    output logic [3:0]    plt_address,
    output logic          plt_data_write,
    output logic [7:0]    plt_data_in,
    output logic          busy,
    output logic          done
);

    localparam int NW = $clog2(DEPTH);
    localparam int NB = DEPTH / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    localparam logic [3:0] A_DATA     = 4'b0000;
    localparam logic [3:0] A_SPI      = 4'b0001;
    localparam logic [3:0] A_DC_PRESC = 4'b0010;
    localparam logic [3:0] A_SEL      = 4'b1000;

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_CAP, S_STROBE, S_GAP, S_WAIT
    } state_t;

    // Position within the per-run command list; C_END means only the done pulse remains.
    typedef enum logic [2:0] {
        C_DCP, C_SPI_LO, C_SPI_HI, C_SEL, C_DATA, C_FIN, C_END
    } step_t;

    state_t              state_q, state_d;
    step_t               step_q, step_d;
    logic [CW-1:0]       ch_q, ch_d;
    logic [BW-1:0]       byte_q, byte_d;
    logic [NW-1:0]       n_q, n_d;
    logic [7:0]          div_cnt_q, div_cnt_d;
    logic [7:0]          div_q, div_d;
    logic [3:0]          presc_q, presc_d;
    logic                gnd_q, gnd_d;
    logic [2:0]          trig_ch_q, trig_ch_d;
    logic                prev_q, prev_d;
    logic [DEPTH-1:0]    samp_q [CH];
    logic [DEPTH-1:0]    samp_d [CH];
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wr_q, wr_d;
    logic [3:0]          addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;

    // Channel select that reads as 0 for indices beyond the probe width, so those never trigger.
    function automatic logic pick_bit(input logic [CH-1:0] p, input logic [2:0] idx);
        logic r;
        r = 1'b0;
        for (int c = 0; c < CH; c++) begin
            if (idx == 3'(c)) r = p[c];
        end
        return r;
    endfunction

    logic             trig_cur;
    logic [DEPTH-1:0] row;
    logic [7:0]       win;
    logic [7:0]       data_byte;

    // Current DATA byte: earliest sample of the 8-sample window lands in bit 7.
    always_comb begin
        trig_cur = pick_bit(probe, trig_ch_q);
        row      = samp_q[ch_q];
        win      = 8'(row >> {byte_q, 3'b000});
        data_byte = '0;
        for (int k = 0; k < 8; k++) begin
            data_byte[7-k] = win[k];
        end
    end

    // Next-state logic for the capture FSM and the plotter command sequencer.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        ch_d      = ch_q;
        byte_d    = byte_q;
        n_d       = n_q;
        div_cnt_d = div_cnt_q;
        div_d     = div_q;
        presc_d   = presc_q;
        gnd_d     = gnd_q;
        trig_ch_d = trig_ch_q;
        prev_d    = prev_q;
        samp_d    = samp_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        wr_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;

        case (state_q)
            S_IDLE: begin
                // done_q blocks a start that lands on the done cycle
                if (start && !done_q) begin
                    div_d     = div;
                    presc_d   = presc;
                    gnd_d     = gnd;
                    trig_ch_d = trig_ch;
                    prev_d    = pick_bit(probe, trig_ch);
                    n_d       = '0;
                    div_cnt_d = '0;
                    ch_d      = '0;
                    byte_d    = '0;
                    step_d    = C_DCP;
                    busy_d    = 1'b1;
                    state_d   = trig_en ? S_ARM : S_CAP;
                end
            end
            S_ARM: begin
                prev_d = trig_cur;
                if (!prev_q && trig_cur) state_d = S_CAP;
            end
            S_CAP: begin
                if (div_cnt_q == 8'd0) begin
                    for (int c = 0; c < CH; c++) begin
                        samp_d[c][n_q] = probe[c];
                    end
                    div_cnt_d = div_q;
                    n_d       = n_q + NW'(1);
                    if (n_q == NW'(DEPTH - 1)) begin
                        n_d     = '0;
                        state_d = S_WAIT;
                    end
                end else begin
                    div_cnt_d = div_cnt_q - 8'd1;
                end
            end
            S_STROBE: state_d = S_GAP;
            S_GAP:    state_d = S_WAIT;
            S_WAIT: begin
                if (plt_idle) begin
                    if (step_q == C_END) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        step_d  = C_DCP;
                        state_d = S_IDLE;
                    end else begin
                        wr_d    = 1'b1;
                        state_d = S_STROBE;
                        case (step_q)
                            C_DCP: begin
                                addr_d  = A_DC_PRESC;
                                wdata_d = {1'b0, gnd_q, 1'b1, 1'b0, presc_q};
                                step_d  = C_SPI_LO;
                            end
                            C_SPI_LO: begin
                                addr_d  = A_SPI;
                                wdata_d = 8'h00;
                                step_d  = C_SPI_HI;
                            end
                            C_SPI_HI: begin
                                addr_d  = A_SPI;
                                wdata_d = 8'h10;
                                step_d  = C_SEL;
                            end
                            C_SEL: begin
                                addr_d  = A_SEL;
                                wdata_d = 8'(ch_q);
                                byte_d  = '0;
                                step_d  = C_DATA;
                            end
                            C_DATA: begin
                                addr_d  = A_DATA;
                                wdata_d = data_byte;
                                if (byte_q == BW'(NB - 1)) begin
                                    byte_d = '0;
                                    if (ch_q == CW'(CH - 1)) begin
                                        step_d = C_FIN;
                                    end else begin
                                        ch_d   = ch_q + CW'(1);
                                        step_d = C_DCP;
                                    end
                                end else begin
                                    byte_d = byte_q + BW'(1);
                                end
                            end
                            C_FIN: begin
                                addr_d  = A_DC_PRESC;
                                wdata_d = {1'b0, gnd_q, 1'b1, 1'b1, presc_q};
                                step_d  = C_END;
                            end
                            default: begin
                                wr_d    = 1'b0;
                                step_d  = C_END;
                                state_d = S_WAIT;
                            end
                        endcase
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset aborts a run and clears the sample buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            step_q    <= C_DCP;
            ch_q      <= '0;
            byte_q    <= '0;
            n_q       <= '0;
            div_cnt_q <= '0;
            div_q     <= '0;
            presc_q   <= '0;
            gnd_q     <= 1'b0;
            trig_ch_q <= '0;
            prev_q    <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                samp_q[c] <= '0;
            end
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            ch_q      <= ch_d;
            byte_q    <= byte_d;
            n_q       <= n_d;
            div_cnt_q <= div_cnt_d;
            div_q     <= div_d;
            presc_q   <= presc_d;
            gnd_q     <= gnd_d;
            trig_ch_q <= trig_ch_d;
            prev_q    <= prev_d;
            samp_q    <= samp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign plt_address    = addr_q;
    assign plt_data_write = wr_q;
    assign plt_data_in    = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// tb/tb_wave_sequencer.sv - directed table-driven bench for wave_sequencer
module tb_wave_sequencer;

    localparam int CH    = 4;
    localparam int DEPTH = 16;
    localparam int NWR   = CH * 6 + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] probe = '0;
    logic [7:0] div = '0;
    logic       trig_en = 1'b0;
    logic [2:0] trig_ch = '0;
    logic [3:0] presc = '0;
    logic       gnd = 1'b0;
    logic       plt_idle;
    logic [3:0] plt_address;
    logic       plt_data_write;
    logic [7:0] plt_data_in;
    logic       busy;
    logic       done;

    wave_sequencer #(.CH(CH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .probe          (probe),
        .div            (div),
        .trig_en        (trig_en),
        .trig_ch        (trig_ch),
        .presc          (presc),
        .gnd            (gnd),
        .plt_idle       (plt_idle),
        .plt_address    (plt_address),
        .plt_data_write (plt_data_write),
        .plt_data_in    (plt_data_in),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Plotter model: busy for 3 cycles after each write (200 after DATA in long mode).
    int   plt_cnt = 0;
    logic long_data = 1'b0;
    always @(posedge clk) begin
        if (plt_data_write)
            plt_cnt <= (long_data && plt_address == 4'b0000) ? 200 : 3;
        else if (plt_cnt > 0)
            plt_cnt <= plt_cnt - 1;
    end
    assign plt_idle = (plt_cnt == 0);

    // Write/done recorder
    logic [3:0] wr_addr [$];
    logic [7:0] wr_data [$];
    int         wr_cyc  [$];
    int         done_cnt = 0;
    int         spacing_err = 0;
    int         last_wr = -100;
    always @(negedge clk) begin
        if (plt_data_write) begin
            wr_addr.push_back(plt_address);
            wr_data.push_back(plt_data_in);
            wr_cyc.push_back(cyc);
            if (cyc - last_wr < 2) spacing_err++;
            last_wr = cyc;
        end
        if (done) done_cnt++;
    end

    typedef struct {
        logic [3:0]       probe;
        logic [7:0]       div;
        logic [3:0]       presc;
        logic             gnd;
        logic [7:0]       dcp;
        logic [7:0]       fin;
        logic [3:0][15:0] data;
        int               first;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    task automatic do_start(output int acc);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        int d0;
        n = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check({tag, " done_within_budget"}, (n < budget) ? 1 : 0, 1);
    endtask

    task automatic compare_run(input string tag, input int base, input logic [7:0] dcp,
                               input logic [7:0] fin, input logic [3:0][15:0] data);
        logic [3:0] ea [NWR];
        logic [7:0] ed [NWR];
        int i;
        i = 0;
        for (int c = 0; c < CH; c++) begin
            ea[i] = 4'h2; ed[i] = dcp;             i++;
            ea[i] = 4'h1; ed[i] = 8'h00;           i++;
            ea[i] = 4'h1; ed[i] = 8'h10;           i++;
            ea[i] = 4'h8; ed[i] = 8'(c);           i++;
            ea[i] = 4'h0; ed[i] = data[c][15:8];   i++;
            ea[i] = 4'h0; ed[i] = data[c][7:0];    i++;
        end
        ea[i] = 4'h2; ed[i] = fin;
        check({tag, " write_count"}, wr_addr.size() - base, NWR);
        for (int j = 0; j < NWR; j++) begin
            if (base + j < wr_addr.size()) begin
                check($sformatf("%s wr%0d addr", tag, j), int'(wr_addr[base+j]), int'(ea[j]));
                check($sformatf("%s wr%0d data", tag, j), int'(wr_data[base+j]), int'(ed[j]));
            end
        end
    endtask

    task automatic run_vec(input string tag, input int v);
        int base;
        int acc;
        int d0;
        probe   = vecs[v].probe;
        div     = vecs[v].div;
        presc   = vecs[v].presc;
        gnd     = vecs[v].gnd;
        trig_en = 1'b0;
        base = wr_addr.size();
        d0   = done_cnt;
        do_start(acc);
        check({tag, " busy_after_start"}, int'(busy), 1);
        wait_done(tag, 6000);
        @(negedge clk);
        check({tag, " done_pulses"}, done_cnt - d0, 1);
        check({tag, " busy_end"}, int'(busy), 0);
        compare_run(tag, base, vecs[v].dcp, vecs[v].fin, vecs[v].data);
        if (wr_cyc.size() > base + 1) begin
            check({tag, " first_strobe"}, wr_cyc[base] - acc, vecs[v].first);
            check({tag, " strobe_gap"}, wr_cyc[base+1] - wr_cyc[base], 5);
        end
    endtask

    initial begin
        int base;
        int acc;
        int d0;
        int n;
        int cnt_r;

        vecs[0] = '{4'b0101, 8'd0,   4'h5, 1'b1, 8'h65, 8'h75,
                    {16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF}, 17};
        vecs[1] = '{4'b1010, 8'd2,   4'h0, 1'b0, 8'h20, 8'h30,
                    {16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000}, 47};
        vecs[2] = '{4'b1100, 8'd0,   4'hF, 1'b0, 8'h2F, 8'h3F,
                    {16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000}, 17};
        vecs[3] = '{4'b0011, 8'd255, 4'hA, 1'b1, 8'h6A, 8'h7A,
                    {16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF}, 3842};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset write", int'(plt_data_write), 0);
        check("reset addr", int'(plt_address), 0);
        check("reset data", int'(plt_data_in), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // constant-probe vectors, including div=255
        for (int v = 0; v < 4; v++) begin
            run_vec($sformatf("vec%0d", v), v);
        end

        // div=3 with toggling probe[0]; config changed after start must not matter
        probe = 4'b1100; div = 8'd3; presc = 4'h0; gnd = 1'b0; trig_en = 1'b0;
        base = wr_addr.size();
        do_start(acc);
        div = 8'd0; presc = 4'hF; gnd = 1'b1; trig_en = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            logic b;
            b = 1'(((k - 1) / 4) % 2);
            probe = {3'b110, b};
            @(posedge clk); #1;
        end
        wait_done("div3", 3000);
        compare_run("div3", base, 8'h20, 8'h30, {16'hFFFF, 16'hFFFF, 16'h0000, 16'h5555});
        if (wr_cyc.size() > base) check("div3 first_strobe", wr_cyc[base] - acc, 62);
        trig_en = 1'b0;

        // trigger on channel 2: high at start, low, fresh rising edge at cycle 40
        probe = 4'b0100; div = 8'd0; presc = 4'h0; gnd = 1'b0; trig_en = 1'b1; trig_ch = 3'd2;
        base = wr_addr.size();
        do_start(acc);
        trig_en = 1'b0; trig_ch = 3'd0;
        for (int k = 1; k <= 60; k++) begin
            logic p2;
            logic p0;
            p2 = (k <= 10 || k >= 40);
            p0 = (k <= 40 || k >= 49);
            probe = {1'b0, p2, 1'b0, p0};
            @(posedge clk); #1;
        end
        wait_done("trig", 3000);
        compare_run("trig", base, 8'h20, 8'h30, {16'h0000, 16'hFFFF, 16'h0000, 16'h00FF});
        if (wr_cyc.size() > base) check("trig first_strobe", wr_cyc[base] - acc, 57);

        // plotter busy for 200 cycles after each DATA write
        long_data = 1'b1;
        probe = 4'b0101; div = 8'd0;
        base = wr_addr.size();
        do_start(acc);
        wait_done("long", 20000);
        long_data = 1'b0;
        compare_run("long", base, 8'h20, 8'h30, {16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF});
        if (wr_cyc.size() > base + 6) begin
            check("long sel_to_data", wr_cyc[base+4] - wr_cyc[base+3], 5);
            check("long data_to_data", wr_cyc[base+5] - wr_cyc[base+4], 202);
            check("long data_to_dcp", wr_cyc[base+6] - wr_cyc[base+5], 202);
        end

        // start during DATA phase and on the done cycle are both ignored
        probe = 4'b1010; div = 8'd0;
        base = wr_addr.size();
        d0 = done_cnt;
        do_start(acc);
        n = 0;
        while (wr_addr.size() < base + 5 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("busystart reached_data", (n < 500) ? 1 : 0, 1);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        @(negedge clk);
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("busystart done_seen", (n < 2000) ? 1 : 0, 1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("busystart busy_after", int'(busy), 0);
        check("busystart done_pulses", done_cnt - d0, 1);
        compare_run("busystart", base, 8'h20, 8'h30, {16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000});

        // reset while waiting after the SEL write
        probe = 4'b0101; div = 8'd0;
        base = wr_addr.size();
        do_start(acc);
        n = 0;
        while (wr_addr.size() < base + 4 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("rst reached_sel", (n < 500) ? 1 : 0, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst write", int'(plt_data_write), 0);
        check("rst addr", int'(plt_address), 0);
        check("rst data", int'(plt_data_in), 0);
        cnt_r = wr_addr.size();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("rst no_strobes_after", wr_addr.size() - cnt_r, 0);
        run_vec("after_rst", 0);

        check("strobe spacing violations", spacing_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
